bounce_physics_ctl: RTL and testbench



---
 rtl/bounce_pkg.sv | 25 ++
 rtl/bounce_tick_gen.sv | 34 +++
 rtl/bounce_physics_ctl.sv | 178 +++++++++++++++++
 tb/tb_bounce_physics_ctl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_pkg.sv
// Shared definitions for the bounce physics controller: state encoding and
// the limits and widths that follow from the default screen/object geometry.
package bounce_pkg;

  localparam int DEF_SCREEN_WIDTH  = 800;
  localparam int DEF_SCREEN_HEIGHT = 600;
  localparam int DEF_OBJ_WIDTH     = 48;
  localparam int DEF_OBJ_HEIGHT    = 64;
  localparam int DEF_FRAC_BITS     = 4;

  // Largest top-left coordinate that keeps the object fully on screen.
  localparam int XMAX = DEF_SCREEN_WIDTH - DEF_OBJ_WIDTH;
  localparam int YMAX = DEF_SCREEN_HEIGHT - DEF_OBJ_HEIGHT;

  // Signed fixed-point widths of position and velocity.
  localparam int POS_W = 13 + DEF_FRAC_BITS;
  localparam int VEL_W = 12 + DEF_FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FLY  = 2'b01,
    REST = 2'b10
  } bounce_state_t;

endpackage

// File: rtl/bounce_tick_gen.sv
// Physics tick divider: counts clk cycles while enabled and pulses tick on the
// last count of each period. Clearing restarts the period so the first tick
// after launch lands exactly TICK_DIV cycles later.
module bounce_tick_gen #(
  parameter int TICK_DIV = 400_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  // Period counter; parked at zero whenever the divider is idle or cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear || !enable) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = enable && !clear && (cnt_reg == LAST);

endmodule

// File: rtl/bounce_physics_ctl.sv
// Drop-and-bounce position controller. The object follows the mouse until a
// click launches it; it then falls under fixed-point gravity, bounces off the
// floor with fractional restitution, reflects off walls and ceiling, and
// settles. xpos/ypos feed the image drawing stage.
module bounce_physics_ctl
  import bounce_pkg::*;
#(
  parameter int SCREEN_WIDTH   = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT  = DEF_SCREEN_HEIGHT,
  parameter int OBJ_WIDTH      = DEF_OBJ_WIDTH,
  parameter int OBJ_HEIGHT     = DEF_OBJ_HEIGHT,
  parameter int FRAC_BITS      = DEF_FRAC_BITS,
  parameter int TICK_DIV       = 400_000,
  parameter int GRAVITY        = 16,
  parameter int REST_NUM       = 11,
  parameter int REST_SHIFT     = 4,
  parameter int MIN_BOUNCE_VEL = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic [7:0]  launch_xvel,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        moving,
  output logic        landed
);

  localparam int PW    = 13 + FRAC_BITS;
  localparam int VW    = 12 + FRAC_BITS;
  localparam int X_LIM = SCREEN_WIDTH - OBJ_WIDTH;
  localparam int Y_LIM = SCREEN_HEIGHT - OBJ_HEIGHT;

  localparam logic [11:0]          X_LIM_PX = 12'(X_LIM);
  localparam logic [11:0]          Y_LIM_PX = 12'(Y_LIM);
  localparam logic signed [PW:0]   X_WALL   = (PW+1)'(X_LIM * (2 ** FRAC_BITS));
  localparam logic signed [PW:0]   Y_FLOOR  = (PW+1)'(Y_LIM * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0] X_CLAMP  = PW'(X_LIM * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0] Y_CLAMP  = PW'(Y_LIM * (2 ** FRAC_BITS));
  localparam logic signed [VW-1:0] GRAV_V   = VW'(GRAVITY);
  localparam logic signed [VW+7:0] REST_C   = (VW+8)'(REST_NUM);
  localparam logic signed [VW+7:0] MIN_C    = (VW+8)'(MIN_BOUNCE_VEL);

  bounce_state_t state_reg, state_next;

  logic signed [PW-1:0] px_reg, px_next, py_reg, py_next;
  logic signed [VW-1:0] vx_reg, vx_next, vy_reg, vy_next;
  logic                 left_reg;
  logic                 click;
  logic                 launch;
  logic                 landed_next;
  logic                 fly_en;
  logic                 tick;

  logic [11:0]          mx_clamp, my_clamp;
  logic signed [VW-1:0] vy_g;
  logic signed [PW:0]   py_sum, px_sum;
  logic signed [VW+7:0] reb_prod, reb_shift;
  logic                 reb_small;

  // A click is a rising edge of the button against its registered history.
  assign click  = mouse_left & ~left_reg;
  assign fly_en = (state_reg == FLY);

  bounce_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (fly_en),
    .clear  (launch),
    .tick   (tick)
  );

  // Next-state and physics update: mouse tracking, launch, and one
  // semi-implicit integration step per tick with per-axis collisions.
  always_comb begin
    state_next  = state_reg;
    px_next     = px_reg;
    py_next     = py_reg;
    vx_next     = vx_reg;
    vy_next     = vy_reg;
    landed_next = 1'b0;
    launch      = 1'b0;

    mx_clamp = (mouse_xpos > X_LIM_PX) ? X_LIM_PX : mouse_xpos;
    my_clamp = (mouse_ypos > Y_LIM_PX) ? Y_LIM_PX : mouse_ypos;

    // Gravity is applied before the position step (semi-implicit Euler).
    vy_g      = vy_reg + GRAV_V;
    py_sum    = {py_reg[PW-1], py_reg} + {{(PW+1-VW){vy_g[VW-1]}}, vy_g};
    px_sum    = {px_reg[PW-1], px_reg} + {{(PW+1-VW){vx_reg[VW-1]}}, vx_reg};
    reb_prod  = {{8{vy_g[VW-1]}}, vy_g} * REST_C;
    reb_shift = reb_prod >>> REST_SHIFT;
    reb_small = (reb_shift < MIN_C) && (reb_shift > -MIN_C);

    case (state_reg)
      IDLE: begin
        px_next = {{(PW-12-FRAC_BITS){1'b0}}, mx_clamp, {FRAC_BITS{1'b0}}};
        py_next = {{(PW-12-FRAC_BITS){1'b0}}, my_clamp, {FRAC_BITS{1'b0}}};
        if (click) begin
          launch     = 1'b1;
          vx_next    = {{(VW-8){launch_xvel[7]}}, launch_xvel};
          vy_next    = '0;
          state_next = FLY;
        end
      end
      FLY: begin
        if (tick) begin
          vy_next = vy_g;
          py_next = py_sum[PW-1:0];
          px_next = px_sum[PW-1:0];
          if (py_sum >= Y_FLOOR) begin
            py_next = Y_CLAMP;
            vy_next = -reb_shift[VW-1:0];
            if (reb_small) begin
              vy_next     = '0;
              state_next  = REST;
              landed_next = 1'b1;
            end
          end else if (py_sum[PW]) begin
            py_next = '0;
            vy_next = -vy_g;
          end
          // Touching a wall exactly is not a hit; only overshoot reflects.
          if (px_sum[PW]) begin
            px_next = '0;
            vx_next = -vx_reg;
          end else if (px_sum > X_WALL) begin
            px_next = X_CLAMP;
            vx_next = -vx_reg;
          end
          if (landed_next) begin
            vx_next = '0;
          end
        end
      end
      REST: begin
        if (click) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, physics and output registers; outputs mirror the updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      px_reg    <= '0;
      py_reg    <= '0;
      vx_reg    <= '0;
      vy_reg    <= '0;
      left_reg  <= 1'b0;
      xpos      <= '0;
      ypos      <= '0;
      moving    <= 1'b0;
      landed    <= 1'b0;
    end else begin
      state_reg <= state_next;
      px_reg    <= px_next;
      py_reg    <= py_next;
      vx_reg    <= vx_next;
      vy_reg    <= vy_next;
      left_reg  <= mouse_left;
      xpos      <= px_next[FRAC_BITS +: 12];
      ypos      <= py_next[FRAC_BITS +: 12];
      moving    <= (state_next == FLY);
      landed    <= landed_next;
    end
  end

endmodule

// File: tb/tb_bounce_physics_ctl.sv
// Bench for bounce_physics_ctl: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle against an integer model.
module tb_bounce_physics_ctl;

  localparam int TD   = 4;
  localparam int FB   = 4;
  localparam int SUB  = 16;
  localparam int G    = 16;
  localparam int RN   = 11;
  localparam int RS   = 4;
  localparam int MINV = 32;
  localparam int XM   = 752;
  localparam int YM   = 536;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic [7:0]  launch_xvel = '0;
  logic [11:0] xpos, ypos;
  logic        moving, landed;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: subpixel integers, mode 0=idle 1=flying 2=resting.
  int m_x, m_y, m_vx, m_vy, m_mode, m_cnt;
  bit m_prev, m_landed;

  bounce_physics_ctl #(
    .SCREEN_WIDTH(800), .SCREEN_HEIGHT(600), .OBJ_WIDTH(48), .OBJ_HEIGHT(64),
    .FRAC_BITS(FB), .TICK_DIV(TD), .GRAVITY(G), .REST_NUM(RN),
    .REST_SHIFT(RS), .MIN_BOUNCE_VEL(MINV)
  ) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .launch_xvel(launch_xvel),
    .xpos(xpos), .ypos(ypos), .moving(moving), .landed(landed)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model, advanced on the same edges the DUT sees.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_x = 0; m_y = 0; m_vx = 0; m_vy = 0;
      m_mode = 0; m_cnt = 0; m_prev = 0; m_landed = 0;
    end else begin
      bit click;
      int vy, nx, ny, reb;
      click    = mouse_left && !m_prev;
      m_prev   = mouse_left;
      m_landed = 0;
      if (m_mode == 0) begin
        m_x = ((int'(mouse_xpos) > XM) ? XM : int'(mouse_xpos)) * SUB;
        m_y = ((int'(mouse_ypos) > YM) ? YM : int'(mouse_ypos)) * SUB;
        if (click) begin
          m_vx = int'($signed(launch_xvel));
          m_vy = 0; m_cnt = 0; m_mode = 1;
          $display("launch x=%0d y=%0d vx=%0d", m_x / SUB, m_y / SUB, m_vx);
        end
      end else if (m_mode == 1) begin
        if (m_cnt == TD - 1) begin
          m_cnt = 0;
          vy = m_vy + G;
          ny = m_y + vy;
          nx = m_x + m_vx;
          if (ny >= YM * SUB) begin
            ny  = YM * SUB;
            reb = (vy * RN) >>> RS;
            vy  = -reb;
            if (reb < MINV && reb > -MINV) begin
              vy = 0; m_mode = 2; m_landed = 1;
            end
          end else if (ny < 0) begin
            ny = 0; vy = -vy;
          end
          if (nx < 0) begin
            nx = 0; m_vx = -m_vx;
          end else if (nx > XM * SUB) begin
            nx = XM * SUB; m_vx = -m_vx;
          end
          if (m_landed) begin
            m_vx = 0;
            $display("landed x=%0d y=%0d", nx / SUB, ny / SUB);
          end
          m_x = nx; m_y = ny; m_vy = vy;
        end else begin
          m_cnt++;
        end
      end else if (click) begin
        m_mode = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("xpos", int'(xpos), m_x >>> FB);
    chk("ypos", int'(ypos), m_y >>> FB);
    chk("moving", int'(moving), int'(m_mode == 1));
    chk("landed", int'(landed), int'(m_landed));
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_xpos"}, int'(xpos), 0);
    chk({tag, "_ypos"}, int'(ypos), 0);
    chk({tag, "_moving"}, int'(moving), 0);
    chk({tag, "_landed"}, int'(landed), 0);
  endtask

  initial begin
    int cur_min, last_peak, first_floor, landed_cnt;
    bit seen_floor, rested;

    // 1. asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    @(negedge clk) rst = 1'b0;

    // 2. idle tracking and clamping
    mouse_xpos = 12'd100; mouse_ypos = 12'd200;
    step(1);
    chk("idle_x", int'(xpos), 100);
    chk("idle_y", int'(ypos), 200);
    mouse_xpos = 12'd900; mouse_ypos = 12'd700;
    step(1);
    chk("clamp_x", int'(xpos), 752);
    chk("clamp_y", int'(ypos), 536);

    // 3. vertical drop from (100,200)
    mouse_xpos = 12'd100; mouse_ypos = 12'd200; launch_xvel = 8'd0;
    step(1);
    mouse_left = 1'b1;
    step(1);
    chk("launch_moving", int'(moving), 1);
    chk("launch_y", int'(ypos), 200);
    mouse_left = 1'b0;
    step(4); chk("tick1_y", int'(ypos), 201);
    step(4); chk("tick2_y", int'(ypos), 203);
    step(4); chk("tick3_y", int'(ypos), 206);
    chk("drop_x", int'(xpos), 100);

    // 4. bounce down to rest
    seen_floor = 0; cur_min = YM; last_peak = -1; first_floor = -1;
    landed_cnt = 0; rested = 0;
    for (int i = 0; i < 4000 && !rested; i++) begin
      @(negedge clk);
      if (landed) landed_cnt++;
      if (first_floor >= 0 && i == first_floor + 4)
        chk("rebound_rises", int'(ypos < 536), 1);
      if (int'(ypos) == YM) begin
        if (first_floor < 0) first_floor = i;
        if (seen_floor && cur_min < YM) begin
          if (last_peak >= 0) chk("peak_decreasing", int'(cur_min > last_peak), 1);
          last_peak = cur_min;
        end
        seen_floor = 1; cur_min = YM;
      end else if (seen_floor && int'(ypos) < cur_min) begin
        cur_min = int'(ypos);
      end
      if (!moving) rested = 1;
    end
    chk("rest_reached", int'(rested), 1);
    chk("rest_y", int'(ypos), 536);
    step(5);
    if (landed) landed_cnt++;
    chk("landed_pulses", landed_cnt, 1);
    chk("rest_moving", int'(moving), 0);

    // 5. sideways launch into the right wall
    mouse_left = 1'b1;
    step(1);
    mouse_left = 1'b0;
    mouse_xpos = 12'd740; mouse_ypos = 12'd500; launch_xvel = 8'd64;
    step(2);
    chk("pre_launch_x", int'(xpos), 740);
    mouse_left = 1'b1;
    step(1);
    mouse_left = 1'b0;
    step(4); chk("wall_x1", int'(xpos), 744);
    step(4); chk("wall_x2", int'(xpos), 748);
    step(4); chk("wall_x3", int'(xpos), 752);
    step(4); chk("wall_clamp", int'(xpos), 752);
    step(4); chk("wall_back", int'(xpos), 748);

    // 6. click during flight ignored; held button in rest does not re-arm
    mouse_left = 1'b1;
    step(2);
    chk("fly_click_ignored", int'(moving), 1);
    rested = 0;
    for (int i = 0; i < 5000 && !rested; i++) begin
      @(negedge clk);
      if (!moving) rested = 1;
    end
    chk("rest2_reached", int'(rested), 1);
    mouse_xpos = 12'd300; mouse_ypos = 12'd300;
    step(20);
    chk("held_no_idle_y", int'(ypos), 536);
    chk("held_no_idle_mv", int'(moving), 0);
    mouse_left = 1'b0;
    step(1);
    mouse_left = 1'b1;
    step(1);
    step(1);
    chk("reidle_x", int'(xpos), 300);
    chk("reidle_y", int'(ypos), 300);
    mouse_left = 1'b0;
    step(1);

    // 1b. reset during flight
    mouse_left = 1'b1;
    step(1);
    mouse_left = 1'b0;
    step(10);
    chk("pre_rst_moving", int'(moving), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_fly");
    mouse_xpos = 12'd50; mouse_ypos = 12'd60;
    @(negedge clk) rst = 1'b0;
    step(1);
    chk("post_rst_x", int'(xpos), 50);
    chk("post_rst_y", int'(ypos), 60);
    chk("post_rst_moving", int'(moving), 0);

    // Randomized run, checked by the per-cycle comparison
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) mouse_left = ~mouse_left;
      if ($urandom_range(0, 7) == 0) begin
        mouse_xpos = 12'($urandom_range(0, 1023));
        mouse_ypos = 12'($urandom_range(0, 800));
      end
      launch_xvel = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4999) == 0) begin
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_rand");
        #1 rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
